// File: rtl/beeb_bus_target_if.sv
// rtl/beeb_bus_target_if.sv - 6502 expansion-bus pins shared by the bus target and its driver
interface beeb_bus_target_if;
    logic        PhiIn;
    logic [15:0] Addr;
    logic        R_W_n;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        irq_n;

    modport master (output PhiIn, Addr, R_W_n, data_in, input data_out, data_oe, irq_n);
    modport slave  (input PhiIn, Addr, R_W_n, data_in, output data_out, data_oe, irq_n);
endinterface

// File: rtl/beeb_bus_target.sv
// rtl/beeb_bus_target.sv - 4-register 6502 bus target with host<->device byte FIFOs
module beeb_bus_target #(
    parameter logic [15:0] BASE  = 16'hFCB0,
    parameter int          DEPTH = 16
) (
    input  logic             clock,
    input  logic             Res_n,
    beeb_bus_target_if.slave bus,
    input  logic             h2d_rd,
    output logic [7:0]       h2d_data,
    output logic             h2d_empty,
    input  logic             d2h_wr,
    input  logic [7:0]       d2h_data,
    output logic             d2h_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t        state_q;
    logic          phi_s1_q, phi_s2_q, seen_q, armed_q;
    logic [1:0]    sel_q;
    logic [7:0]    wdata_q, data_out_q, scratch_q;
    logic          irq_en_q, ovf_q, data_oe_q, irq_n_q;
    logic [7:0]    h2d_mem [DEPTH];
    logic [7:0]    d2h_mem [DEPTH];
    logic [AW-1:0] h2d_wp_q, h2d_rp_q, d2h_wp_q, d2h_rp_q;
    logic [CW-1:0] h2d_cnt_q, d2h_cnt_q;

    logic       rise, fall, hit, h2d_full, d2h_empty, irq_pend;
    logic       commit, h2d_push, h2d_push_ok, h2d_pop, d2h_pop, d2h_push_ok;
    logic [7:0] status, rd_mux;

    // A rise seen before the synchroniser has sampled Phi low once after reset
    // belongs to a bus cycle that started during reset and is ignored.
    assign rise = phi_s1_q & ~phi_s2_q & armed_q;
    assign fall = ~phi_s1_q & phi_s2_q;
    assign hit  = (bus.Addr[15:2] == BASE[15:2]);

    assign h2d_full  = (h2d_cnt_q == FULL_CNT);
    assign h2d_empty = (h2d_cnt_q == '0);
    assign d2h_full  = (d2h_cnt_q == FULL_CNT);
    assign d2h_empty = (d2h_cnt_q == '0);
    assign h2d_data  = h2d_mem[h2d_rp_q];

    assign commit      = (state_q == WR) && fall;
    assign h2d_push    = commit && (sel_q == 2'd1);
    assign h2d_pop     = h2d_rd && !h2d_empty;
    assign h2d_push_ok = h2d_push && (!h2d_full || h2d_pop);
    assign d2h_pop     = (state_q == RD) && fall && (sel_q == 2'd1) && !d2h_empty;
    assign d2h_push_ok = d2h_wr && (!d2h_full || d2h_pop);

    assign irq_pend = irq_en_q & ~d2h_empty;
    assign status   = {irq_pend, 4'b0000, ovf_q, ~h2d_full, ~d2h_empty};

    assign bus.data_out = data_out_q;
    assign bus.data_oe  = data_oe_q;
    assign bus.irq_n    = irq_n_q;

    always_comb begin
        rd_mux = 8'hFF;
        case (bus.Addr[1:0])
            2'd0:    rd_mux = status;
            2'd1:    rd_mux = d2h_empty ? 8'hFF : d2h_mem[d2h_rp_q];
            2'd2:    rd_mux = {7'b0000000, irq_en_q};
            default: rd_mux = scratch_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (h2d_push_ok) h2d_mem[h2d_wp_q] <= wdata_q;
        if (d2h_push_ok) d2h_mem[d2h_wp_q] <= d2h_data;
    end

    always_ff @(posedge clock or negedge Res_n) begin
        if (!Res_n) begin
            state_q    <= IDLE;
            phi_s1_q   <= 1'b0;
            phi_s2_q   <= 1'b0;
            seen_q     <= 1'b0;
            armed_q    <= 1'b0;
            sel_q      <= 2'd0;
            wdata_q    <= 8'h00;
            data_out_q <= 8'hFF;
            data_oe_q  <= 1'b0;
            scratch_q  <= 8'h00;
            irq_en_q   <= 1'b0;
            ovf_q      <= 1'b0;
            irq_n_q    <= 1'b1;
            h2d_wp_q   <= '0;
            h2d_rp_q   <= '0;
            h2d_cnt_q  <= '0;
            d2h_wp_q   <= '0;
            d2h_rp_q   <= '0;
            d2h_cnt_q  <= '0;
        end else begin
            phi_s1_q <= bus.PhiIn;
            phi_s2_q <= phi_s1_q;
            seen_q   <= 1'b1;
            if (seen_q && !phi_s1_q) armed_q <= 1'b1;
            irq_n_q  <= ~irq_pend;

            case (state_q)
                IDLE: begin
                    data_oe_q <= 1'b0;
                    if (rise && hit) begin
                        sel_q <= bus.Addr[1:0];
                        if (bus.R_W_n) begin
                            state_q    <= RD;
                            data_out_q <= rd_mux;
                        end else begin
                            state_q <= WR;
                        end
                    end
                end
                RD: begin
                    if (fall) begin
                        state_q   <= IDLE;
                        data_oe_q <= 1'b0;
                    end else begin
                        data_oe_q <= 1'b1;
                    end
                end
                WR: begin
                    data_oe_q <= 1'b0;
                    if (fall) begin
                        state_q <= IDLE;
                        if (sel_q == 2'd2) irq_en_q  <= wdata_q[0];
                        if (sel_q == 2'd3) scratch_q <= wdata_q;
                    end else if (phi_s1_q) begin
                        wdata_q <= bus.data_in;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    data_oe_q <= 1'b0;
                end
            endcase

            // Overflow set takes priority over the STATUS-read clear.
            if (h2d_push && !h2d_push_ok)
                ovf_q <= 1'b1;
            else if ((state_q == RD) && fall && (sel_q == 2'd0))
                ovf_q <= 1'b0;

            if (h2d_push_ok) h2d_wp_q <= h2d_wp_q + AW'(1);
            if (h2d_pop)     h2d_rp_q <= h2d_rp_q + AW'(1);
            if (h2d_push_ok && !h2d_pop)      h2d_cnt_q <= h2d_cnt_q + CW'(1);
            else if (!h2d_push_ok && h2d_pop) h2d_cnt_q <= h2d_cnt_q - CW'(1);

            if (d2h_push_ok) d2h_wp_q <= d2h_wp_q + AW'(1);
            if (d2h_pop)     d2h_rp_q <= d2h_rp_q + AW'(1);
            if (d2h_push_ok && !d2h_pop)      d2h_cnt_q <= d2h_cnt_q + CW'(1);
            else if (!d2h_push_ok && d2h_pop) d2h_cnt_q <= d2h_cnt_q - CW'(1);
        end
    end
endmodule

// File: tb/tb_beeb_bus_target.sv
// tb/tb_beeb_bus_target.sv - scoreboard bench for beeb_bus_target
module tb_beeb_bus_target;
    localparam logic [15:0] BASE = 16'hFCB0;

    logic       clock = 1'b0;
    logic       Res_n = 1'b0;
    logic       h2d_rd = 1'b0;
    logic [7:0] h2d_data;
    logic       h2d_empty;
    logic       d2h_wr = 1'b0;
    logic [7:0] d2h_data = 8'h00;
    logic       d2h_full;

    int vectors = 0;
    int miscompares = 0;
    int oe_viol = 0;
    int phi_low_cnt = 100;
    logic [7:0] exp_q [$];

    beeb_bus_target_if bus();

    beeb_bus_target #(.BASE(BASE), .DEPTH(16)) dut (
        .clock     (clock),
        .Res_n     (Res_n),
        .bus       (bus),
        .h2d_rd    (h2d_rd),
        .h2d_data  (h2d_data),
        .h2d_empty (h2d_empty),
        .d2h_wr    (d2h_wr),
        .d2h_data  (d2h_data),
        .d2h_full  (d2h_full)
    );

    always #8 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One full Phi cycle; address and direction are scrambled mid-Phi2 to
    // show they are only taken at the rising edge.
    task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
        bus.Addr = a; bus.R_W_n = rw; bus.data_in = d;
        clocks(16);
        bus.PhiIn = 1'b1;
        clocks(4);
        bus.Addr = 16'h0000; bus.R_W_n = ~rw;
        clocks(12);
        bus.PhiIn = 1'b0;
        clocks(16);
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [7:0] exp);
        exp_q.push_back(exp);
        bus_cycle(a, 1'b1, 8'h00);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus_cycle(a, 1'b0, d);
    endtask

    task automatic d2h_push(input logic [7:0] d);
        d2h_data = d; d2h_wr = 1'b1;
        clocks(1);
        d2h_wr = 1'b0;
    endtask

    // Monitor: every read data phase pops one expected byte.
    initial begin
        logic prev_oe;
        logic [7:0] e;
        prev_oe = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.data_oe && !prev_oe) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_read: data_out %h driven, expected no drive", bus.data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.data_out !== e) begin
                        miscompares++;
                        $display("FAIL read_data: got %h expected %h", bus.data_out, e);
                    end
                end
            end
            prev_oe = bus.data_oe;
            if (bus.PhiIn) phi_low_cnt = 0;
            else if (phi_low_cnt < 1000) phi_low_cnt++;
            if (bus.data_oe && phi_low_cnt > 4) oe_viol++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.PhiIn = 1'b0; bus.Addr = 16'h0000; bus.R_W_n = 1'b1; bus.data_in = 8'h00;
        #20;
        check("rst_data_oe", {7'b0, bus.data_oe}, 8'h00);
        check("rst_data_out", bus.data_out, 8'hFF);
        check("rst_irq_n", {7'b0, bus.irq_n}, 8'h01);
        check("rst_h2d_empty", {7'b0, h2d_empty}, 8'h01);
        check("rst_d2h_full", {7'b0, d2h_full}, 8'h00);
        clocks(3);
        Res_n = 1'b1;
        clocks(4);

        // Scratch and control round-trip
        bus_write(BASE + 16'd3, 8'hA5);
        bus_read(BASE + 16'd3, 8'hA5);
        bus_read(BASE + 16'd2, 8'h00);

        // Device-to-host data, including empty read
        d2h_push(8'h11);
        d2h_push(8'h22);
        bus_read(BASE, 8'h03);
        bus_read(BASE + 16'd1, 8'h11);
        bus_read(BASE + 16'd1, 8'h22);
        bus_read(BASE + 16'd1, 8'hFF);
        bus_read(BASE, 8'h02);

        // Interrupt request follows pending device data
        bus_write(BASE + 16'd2, 8'h01);
        check("irq_idle", {7'b0, bus.irq_n}, 8'h01);
        d2h_data = 8'h33; d2h_wr = 1'b1;
        clocks(1);
        d2h_wr = 1'b0;
        clocks(1);
        check("irq_assert", {7'b0, bus.irq_n}, 8'h00);
        bus_read(BASE, 8'h83);
        bus_read(BASE + 16'd1, 8'h33);
        check("irq_release", {7'b0, bus.irq_n}, 8'h01);
        bus_write(BASE + 16'd2, 8'h00);

        // Host-to-device overflow: 17th byte dropped
        for (int i = 0; i < 17; i++) bus_write(BASE + 16'd1, 8'(i));
        check("h2d_not_empty", {7'b0, h2d_empty}, 8'h00);
        bus_read(BASE, 8'h04);
        bus_read(BASE, 8'h00);
        for (int i = 0; i < 16; i++) begin
            check("h2d_data", h2d_data, 8'(i));
            h2d_rd = 1'b1;
            clocks(1);
        end
        h2d_rd = 1'b0;
        check("h2d_drained", {7'b0, h2d_empty}, 8'h01);

        // Out-of-window accesses must not respond or change state
        bus_read(BASE + 16'd4, 8'h00);
        void'(exp_q.pop_back());
        bus_read(BASE - 16'd1, 8'h00);
        void'(exp_q.pop_back());
        bus_write(BASE + 16'd4, 8'h55);
        bus_write(BASE - 16'd1, 8'h77);
        bus_read(BASE + 16'd3, 8'hA5);
        check("miss_h2d_empty", {7'b0, h2d_empty}, 8'h01);

        // Reset in the middle of a DATA read
        d2h_push(8'h44);
        exp_q.push_back(8'h44);
        bus.Addr = BASE + 16'd1; bus.R_W_n = 1'b1;
        clocks(16);
        bus.PhiIn = 1'b1;
        clocks(8);
        Res_n = 1'b0;
        #1;
        check("rst_mid_oe", {7'b0, bus.data_oe}, 8'h00);
        clocks(2);
        Res_n = 1'b1;
        clocks(6);
        bus.PhiIn = 1'b0;
        clocks(16);
        check("rst_mid_h2d_empty", {7'b0, h2d_empty}, 8'h01);
        bus_read(BASE, 8'h02);
        bus_read(BASE + 16'd3, 8'h00);
        bus_read(BASE + 16'd1, 8'hFF);

        clocks(8);
        check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        check("oe_outside_phi2", 8'(oe_viol), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/beeb_bus_target.md
BEEB_BUS_TARGET -- requirements
Module: beeb_bus_target

Interface
REQ-001 Parameter BASE, default 16'hFCB0: address of register 0; block decodes BASE..BASE+3 (Addr[15:2] match, Addr[1:0] selects register).
REQ-002 Parameter DEPTH, default 16: entries per FIFO, power of two, 2..64.
REQ-003 clock  in  1  system clock, 64 MHz; all logic on its rising edge.
REQ-004 Res_n  in  1  reset; asynchronous, active-low.
REQ-005 PhiIn  in  1  6502 bus Phi0/Phi2 from motherboard, asynchronous to clock.
REQ-006 Addr  in  16  6502 address bus.
REQ-007 R_W_n  in  1  6502 read/write; 1 = read.
REQ-008 data_in  in  8  6502 data bus, input side of pad.
REQ-009 data_out  out  8  read data to pad.
REQ-010 data_oe  out  1  pad output enable; 1 = drive data_out.
REQ-011 irq_n  out  1  level interrupt request to bus, active-low.
REQ-012 h2d_rd  in  1  internal pop of host-to-device FIFO.
REQ-013 h2d_data  out  8  head of host-to-device FIFO.
REQ-014 h2d_empty  out  1  host-to-device FIFO empty.
REQ-015 d2h_wr  in  1  internal push to device-to-host FIFO.
REQ-016 d2h_data  in  8  data for d2h_wr.
REQ-017 d2h_full  out  1  device-to-host FIFO full.

Function
REQ-018 PhiIn synchronised through two flops (phi_s1, phi_s2); rise = phi_s1 & !phi_s2, fall = !phi_s1 & phi_s2; raw PhiIn used nowhere else.
REQ-019 FSM states IDLE, RD, WR; IDLE->RD on rise with address hit and R_W_n=1; IDLE->WR on rise with hit and R_W_n=0; RD/WR->IDLE on fall; rise without hit stays IDLE.
REQ-020 Addr[1:0] and R_W_n latched on rise; later changes within the cycle ignored.
REQ-021 Registers: 0 STATUS (R), 1 DATA (R/W), 2 CTRL (R/W, bit0 irq_en, bits7:1 read 0), 3 SCRATCH (R/W, 8 bits).
REQ-022 STATUS = {irq_pend, 4'b0, ovf, !h2d_full, !d2h_empty}, sampled at rise.
REQ-023 RD: data_out loaded on the rise clock from selected register (DATA = d2h head, 8'hFF if d2h empty); data_oe = 1 from next clock until fall clock, 0 in all other states.
REQ-024 RD of DATA with d2h non-empty pops d2h on the fall clock; empty read pops nothing.
REQ-025 RD of STATUS clears ovf on the fall clock.
REQ-026 WR: data_in registered every clock in WR while phi_s1=1; value held at fall committed on the fall clock (DATA pushes h2d, CTRL/SCRATCH updated).
REQ-027 WR to DATA with h2d full: byte dropped, ovf set (sticky); STATUS read clears ovf; clear and set on same clock -> set wins.
REQ-028 d2h_wr when d2h full ignored, no flag; h2d_rd when h2d empty ignored.
REQ-029 Simultaneous push and pop on one FIFO: both performed, occupancy unchanged; full FIFO with simultaneous pop+push accepts the push.
REQ-030 Occupancy counters width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-031 irq_pend = irq_en & !d2h_empty; irq_n = !irq_pend, registered.
REQ-032 h2d_data valid whenever h2d_empty = 0 (first-word fall-through).

Reset
REQ-033 Res_n low: FSM IDLE, data_oe 0, data_out 8'hFF, irq_n 1, both FIFOs empty, ovf 0, CTRL 0, SCRATCH 0, sync flops 0; immediate, independent of clock.
REQ-034 Res_n deasserted mid bus cycle: block waits for next rise; partial cycle neither pops nor pushes.

Verification
REQ-035 Write 8'hA5 to BASE+3, read back -> data_out 8'hA5, data_oe high only inside Phi2 of read cycle.
REQ-036 d2h_wr 8'h11, 8'h22; read BASE+1 twice -> 8'h11, 8'h22; third read -> 8'hFF, STATUS bit0 = 0.
REQ-037 17 host writes to BASE+1 (DEPTH 16) -> h2d holds first 16, STATUS = 8'h04 (ovf, full, d2h empty); next STATUS read 8'h00 with h2d still full.
REQ-038 CTRL=1, d2h_wr one byte -> irq_n low within 2 clocks; read DATA -> irq_n high within 2 clocks of fall.
REQ-039 Access to BASE+4 and BASE-1 -> data_oe stays 0, no state change.
REQ-040 Res_n low during RD of DATA with d2h non-empty -> data_oe 0 at once, FIFOs empty after reset, no pop completes.
